// File: rtl/lsu_mem_pkg.sv
// lsu_mem_pkg: shared FSM state type, LFSR seed and range check for the LSU memory responder
package lsu_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} resp_state_e;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base, input logic [32:0] span_bytes);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ({1'b0, off} < span_bytes);
  endfunction
endpackage

// File: rtl/lsu_mem_responder_bram_be.sv
// bram_be: single-port word array with per-byte write enables and a registered read port
module bram_be #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clock)
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
endmodule

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder: fixed-latency LSU data memory with byte-masked writes and range error.
// Define LSU_MEM_RAND_STALL_EN to add an LFSR-driven 0..3 cycle extra stall per request.
module lsu_mem_responder
  import lsu_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic        respValid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 4) + 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
  resp_state_e state;
  logic [CW-1:0] cnt, load;
  logic wen_q, rd_ok, err_q, accept, go_resp, a_wen, a_ok;
  logic [31:0] addr_q, wdata_q, a_addr, a_wdata, q;
  logic [3:0] wmask_q, a_wmask;
  logic [AW-1:0] idx;
`ifdef LSU_MEM_RAND_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clock or posedge reset)
    if (reset) lfsr <= LFSR_SEED;
    else if (accept) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign load = CW'(LATENCY - 1) + CW'(lfsr[1:0]);
`else
  assign load = CW'(LATENCY - 1);
`endif
  // The array access uses live inputs when RESP is entered straight from IDLE.
  always_comb begin
    accept  = state == IDLE && reqValid;
    a_wen   = state == IDLE ? wen : wen_q;
    a_addr  = state == IDLE ? addr : addr_q;
    a_wdata = state == IDLE ? wdata : wdata_q;
    a_wmask = state == IDLE ? wmask : wmask_q;
    go_resp = (accept && load == '0) || (state == WAIT && cnt == CW'(1));
    a_ok    = addr_in_range(a_addr, BASE_ADDR, SPAN);
    idx     = AW'((a_addr - BASE_ADDR) >> 2);
  end
  bram_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clock(clock),
    .en(go_resp && a_ok && !reset),
    .we(a_wen ? a_wmask : 4'b0000),
    .addr(idx),
    .wdata(a_wdata),
    .rdata(q)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_ok   <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      rd_ok <= go_resp && a_ok && !a_wen;
      err_q <= go_resp && !a_ok;
      if (accept) begin
        wen_q   <= wen;
        addr_q  <= addr;
        wdata_q <= wdata;
        wmask_q <= wmask;
        cnt     <= load;
        state   <= load == '0 ? RESP : WAIT;
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= RESP;
      end else if (state == RESP) state <= IDLE;
    end
  assign respValid = state == RESP;
  assign busy      = state != IDLE;
  assign err       = err_q;
  assign rdata     = rd_ok ? q : '0;
endmodule

// File: tb/tb_lsu_mem_responder.sv
// tb_lsu_mem_responder: randomized scoreboard bench for lsu_mem_responder against a word-array model
module tb_lsu_mem_responder;
  localparam int          DEPTH   = 1024;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          LATENCY = 2;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  logic clock = 0, reset = 1, reqValid = 0, wen = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] wmask = 0;
  logic respValid, err, busy;
  logic [31:0] rdata;
  int compared = 0, mismatched = 0, cyc = 0;
  exp_t sb[$];
  logic [31:0] model [DEPTH];
  logic [7:0] m_lfsr = 8'hA5;

  lsu_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LATENCY)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .wen(wen), .addr(addr),
    .wdata(wdata), .wmask(wmask), .respValid(respValid), .rdata(rdata), .err(err), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clock)
    if (!reset && respValid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_resp: got respValid=1 expected none at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", rdata, e.rdata);
        chk("resp_err", 32'(err), 32'(e.err));
        chk("resp_cycle", cyc, e.cyc);
      end
    end

  task automatic wait_idle();
    for (int k = 0; k < 100 && busy; k++) @(negedge clock);
    if (busy) chk("idle_timeout", 32'(busy), 0);
  endtask

  function automatic int next_latency();
    int lat;
    lat = LATENCY;
`ifdef LSU_MEM_RAND_STALL_EN
    lat += int'(m_lfsr % 4);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
    return lat;
  endfunction

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    exp_t e;
    int unsigned i;
    logic inr;
    wait_idle();
    inr = (a >= BASE) && (a - BASE < DEPTH * 4);
    i = ((a - BASE) / 4) % DEPTH;
    e.err = !inr;
    e.rdata = 0;
    if (inr && w)
      for (int b = 0; b < 4; b++) if (m[b]) model[i][8*b +: 8] = d[8*b +: 8];
    if (inr && !w) e.rdata = model[i];
    e.cyc = cyc + next_latency();
    sb.push_back(e);
    reqValid = 1; wen = w; addr = a; wdata = d; wmask = m;
    @(negedge clock);
    reqValid = 0;
    chk("busy_after_accept", 32'(busy), 1);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_respValid", 32'(respValid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", rdata, 0);
    reset = 0;
    @(negedge clock);
    for (int k = 0; k < 64; k++) issue(1, BASE + 32'(k * 4), $urandom, 4'hF);
    issue(1, BASE + 32'hFFC, 32'h5A5A_1234, 4'hF);
    // directed cases
    issue(1, BASE, 32'hDEADBEEF, 4'hF);
    issue(0, BASE, 0, 0);
    issue(1, BASE + 4, 32'h11223344, 4'hF);
    issue(1, BASE + 6, 32'h00AB0000, 4'b0100);
    issue(0, BASE + 4, 0, 0);
    chk("byte_write_model", model[1], 32'h11AB3344);
    issue(1, BASE + 8, 32'hFFFF_FFFF, 4'b0000);
    issue(0, BASE + 8, 0, 0);
    issue(0, BASE + 32'h1000, 0, 0);
    issue(1, 32'h7FFF_FFFC, 32'hCAFEF00D, 4'hF);
    issue(0, BASE + 32'hFFC, 0, 0);
    issue(0, BASE, 0, 0);
    // extra requests while busy must be ignored
    issue(0, BASE + 12, 0, 0);
    reqValid = 1; wen = 1; addr = BASE + 20; wdata = 32'hBAD0_0001; wmask = 4'hF;
    @(negedge clock);
    reqValid = 0;
    for (int k = 0; k < 20 && !respValid; k++) @(negedge clock);
    reqValid = 1; wdata = 32'hBAD0_0002;
    @(negedge clock);
    reqValid = 0;
    issue(0, BASE + 20, 0, 0);
    // reset during a pending write drops it
    wait_idle();
    reqValid = 1; wen = 1; addr = BASE + 24; wdata = 32'h0BAD_0BAD; wmask = 4'hF;
    @(negedge clock);
    reqValid = 0;
    reset = 1;
    #1;
    chk("midrst_respValid", 32'(respValid), 0);
    chk("midrst_busy", 32'(busy), 0);
    m_lfsr = 8'hA5;
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    issue(0, BASE + 24, 0, 0);
    // back-to-back reads then random traffic
    for (int k = 0; k < 16; k++) issue(0, BASE + 32'(k * 4), 0, 0);
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0)
        a = $urandom_range(0, 1) ? BASE + 32'h1000 + ($urandom & 32'hFFFF) : BASE - 32'd1 - ($urandom & 32'hFFFF);
      else
        a = BASE + 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    wait_idle();
    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/lsu_mem_responder.md
Name: lsu_mem_responder

Overview:
- Memory-side responder for the LSU request/response handshake. Accepts one single-cycle request pulse (reqValid), performs a byte-masked write or a full-word read on an internal word-addressed array, and returns a one-cycle respValid pulse after a fixed latency.
- Sits between the core's LSU and data memory. Serves as the simulation data memory for the SoC.
- Address alignment, data rotation and sign extension stay in the LSU. The responder works on aligned words plus a 4-bit byte mask.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array. Must be a power of 2.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 2: cycles from acceptance to respValid. Must be 1 or more.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reqValid  in  1  one-cycle request pulse from the LSU
- wen  in  1  1 = write, 0 = read; sampled with reqValid
- addr  in  32  byte address; bits [1:0] are ignored
- wdata  in  32  pre-rotated write data
- wmask  in  4  byte enables; bit i enables wdata[8i+7:8i]
- respValid  out  1  one-cycle response pulse
- rdata  out  32  read word; valid only while respValid is high
- err  out  1  out-of-range access; valid only while respValid is high
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: clock is clock; reset is reset, asynchronous, active-high.
  - Reset values: state = IDLE, respValid = 0, err = 0, rdata = 0, busy = 0, counter = 0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - reqValid = 1 at a rising edge (acceptance cycle = cycle 0): latch wen, addr, wdata, wmask; load counter with LATENCY-1.
  - Next state is WAIT if LATENCY > 1, else RESP.
- WAIT: counter decrements each cycle. When counter == 1 the next state is RESP.
- RESP (cycle LATENCY):
  - respValid = 1 for exactly one cycle; next state is IDLE unconditionally.
- Array access timing:
  - The access happens at the edge entering RESP.
  - Write: for each bit i with wmask[i] = 1, mem[idx] byte i = wdata byte i. Bytes with mask 0 are unchanged. wmask = 0 writes nothing and still responds.
  - Read: rdata = mem[idx] as a full word. The LSU does alignment and extension.
  - Write response: rdata = 0.
- Address index:
  - off = addr - BASE_ADDR (32-bit wrap arithmetic).
  - idx = off[log2(DEPTH_WORDS)+1:2].
  - In range iff addr >= BASE_ADDR and off < DEPTH_WORDS*4.
- Out of range:
  - No write; rdata = 0.
  - err = 1 together with respValid. Latency is unchanged.
- reqValid while not IDLE (including the RESP cycle): ignored, no state change. The protocol allows only one outstanding request.
- Read-after-write: a read accepted after a write's respValid returns the new data.
- Reset mid-operation: the pending request is dropped and an uncommitted write never reaches the array.
- Outputs driven from registers only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: LSU_MEM_RAND_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded to 8'hA5 on reset, stepped on every acceptance.
  - Each request waits LATENCY + lfsr[1:0] cycles (counter loads LATENCY-1+lfsr[1:0]).
  - Used to stress LSU handling of a variable wait.
- Undefined: fixed LATENCY; no LFSR logic.

Decomposition:
- Package lsu_mem_pkg:
  - resp_state_e enum {IDLE, WAIT, RESP}
  - LFSR_SEED = 8'hA5
  - function for the in-range check
- Sub-module bram_be: single-port synchronous array, DEPTH_WORDS x 32, per-byte write enable, registered read. Instantiated once.

Test Plan:
- LATENCY=2 read: preload mem[0] = 32'hDEADBEEF; reqValid, wen=0, addr = 32'h8000_0000 in cycle 0 -> respValid only in cycle 2, rdata = 32'hDEADBEEF, err = 0, busy high in cycles 1-2.
- Byte write: mem[1] = 32'h11223344; write addr 32'h8000_0006, wmask = 4'b0100, wdata = 32'h00AB0000; then read the same word -> 32'h11AB3344.
- Out of range: read addr 32'h8000_1000 (DEPTH_WORDS = 1024) -> respValid at cycle 2 with err = 1, rdata = 0; a write to 32'h7FFF_FFFC alters no word.
- Busy drop: second reqValid in cycle 1 and in the RESP cycle -> ignored; exactly one respValid; array unchanged by the second request.
- Reset mid-op: write accepted, reset asserted in cycle 1 -> respValid = 0, busy = 0 immediately; a subsequent read returns the old value.
- LSU_MEM_RAND_STALL_EN: 16 back-to-back reads -> each latency is in 2..5 and matches the reference LFSR sequence from seed 8'hA5; all data correct.
